// File: rtl/sample_iter_pkg.sv
// sample_iter_pkg: shared FSM state type and subsample pitch helpers for the sample iterator.
package sample_iter_pkg;
    typedef enum logic {WAIT, TEST} state_t;
    function automatic logic [1:0] ss_w_lg2(input logic [3:0] ss);
        return ss[0] ? 2'd3 : ss[1] ? 2'd2 : ss[2] ? 2'd1 : 2'd0;
    endfunction
    function automatic logic [31:0] step(input int radix, input logic [1:0] lg2);
        return 32'd1 << (radix - int'(lg2));
    endfunction
endpackage

// File: rtl/sample_iterator_smpl_next.sv
// smpl_next: raster-order successor of the current sample inside the box, flagging when that successor is the final corner.
module smpl_next #(
    parameter int SIGFIG = 24
) (
    input  logic signed [SIGFIG-1:0] samp_i [2],
    input  logic signed [SIGFIG-1:0] box_i [2][2],
    input  logic signed [SIGFIG-1:0] step_i,
    output logic signed [SIGFIG-1:0] next_o [2],
    output logic                     is_last_o
);
    logic signed [SIGFIG-1:0] x_inc;
    logic                     in_row;
    assign x_inc     = samp_i[0] + step_i;
    assign in_row    = x_inc <= box_i[1][0];
    assign next_o[0] = in_row ? x_inc : box_i[0][0];
    assign next_o[1] = in_row ? samp_i[1] : samp_i[1] + step_i;
    // is_last_o describes the successor, so the FSM can leave TEST as the last sample is registered
    assign is_last_o = (next_o[0] == box_i[1][0]) && (next_o[1] == box_i[1][1]);
endmodule

// File: rtl/sample_iterator.sv
// sample_iterator: accepts a triangle and its bbox, then walks the box at subsample pitch emitting one sample per cycle.
module sample_iterator
    import sample_iter_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic                     validTri_R13H,
    input  logic [3:0]               subSample_RnnnnU,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2],
    output logic                     validSamp_R14H
);
    state_t                   state_q, state_d;
    logic signed [SIGFIG-1:0] tri_q [VERTS][AXIS];
    logic signed [SIGFIG-1:0] tri_d [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_q [COLORS];
    logic        [SIGFIG-1:0] color_d [COLORS];
    logic signed [SIGFIG-1:0] box_q [2][2];
    logic signed [SIGFIG-1:0] box_d [2][2];
    logic signed [SIGFIG-1:0] samp_q [2];
    logic signed [SIGFIG-1:0] samp_d [2];
    logic signed [SIGFIG-1:0] samp_nxt [2];
    logic signed [SIGFIG-1:0] step_w;
    logic                     valid_q, valid_d;
    logic                     nxt_last;
    logic                     single;
    assign step_w = SIGFIG'(step(RADIX, ss_w_lg2(subSample_RnnnnU)));
    assign single = (box_R13S[0][0] == box_R13S[1][0]) && (box_R13S[0][1] == box_R13S[1][1]);
    smpl_next #(.SIGFIG(SIGFIG)) u_next (
        .samp_i    (samp_q),
        .box_i     (box_q),
        .step_i    (step_w),
        .next_o    (samp_nxt),
        .is_last_o (nxt_last)
    );
    always_comb begin
        state_d = state_q;
        tri_d   = tri_q;
        color_d = color_q;
        box_d   = box_q;
        samp_d  = samp_q;
        valid_d = 1'b0;
        if (state_q == TEST) begin
            samp_d  = samp_nxt;
            valid_d = 1'b1;
            state_d = nxt_last ? WAIT : TEST;
        end else if (validTri_R13H) begin
            tri_d   = tri_R13S;
            color_d = color_R13U;
            box_d   = box_R13S;
            samp_d  = box_R13S[0];
            valid_d = 1'b1;
            state_d = single ? WAIT : TEST;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT;
            tri_q   <= '{default: '0};
            color_q <= '{default: '0};
            box_q   <= '{default: '0};
            samp_q  <= '{default: '0};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tri_q   <= tri_d;
            color_q <= color_d;
            box_q   <= box_d;
            samp_q  <= samp_d;
            valid_q <= valid_d;
        end
    end
    // Upstream is free whenever no multi-sample walk is in flight, including the cycle the last sample is out
    assign halt_RnnnnL    = state_q != TEST;
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = samp_q;
    assign validSamp_R14H = valid_q;
endmodule
